// File: rtl/l1a_pkg.sv
// l1a_pkg: shared tag width, dispatcher FSM encoding and tag-lane slicing helper
package l1a_pkg;
    localparam int L1A_W = 14;
    localparam int MAX_NCH = 16;
    typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT, DONE} l1a_disp_state_t;
    function automatic logic [L1A_W-1:0] lane_tag(input logic [MAX_NCH*L1A_W-1:0] bus, input int k);
        return bus[k*L1A_W +: L1A_W];
    endfunction
endpackage

// File: rtl/l1a_tag_fifo.sv
// l1a_tag_fifo: first-word-fall-through synchronous queue of pending L1A tags
//   clk, reset (sync, active-high); push/din write; pop/dout read (dout valid while !empty);
//   full, empty status. A push while full is accepted only when a pop happens in the same cycle.
module l1a_tag_fifo
    import l1a_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [L1A_W-1:0] din,
    output logic [L1A_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [L1A_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/l1a_tag_dispatcher.sv
// l1a_tag_dispatcher: tags level-1 accepts and sequences them onto per-channel L1A buses
//   clk, reset (sync, active-high); l1a_in accept pulse; finish_ack/align_in from the checker;
//   l1a_bus per-channel tag lanes; trig_out one-hot update strobe; start_check, check_in_progress
//   transaction status; fifo_full, overflow, timeout_err status; evt_cnt, misalign_cnt statistics.
//   Optional L1A_ERR_INJECT_EN adds inj_arm/inj_ch to flip tag bit 0 on one lane for one transaction.
module l1a_tag_dispatcher
    import l1a_pkg::*;
#(
    parameter int NCH = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ACK_TO = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 l1a_in,
    input  logic                 finish_ack,
    input  logic                 align_in,
`ifdef L1A_ERR_INJECT_EN
    input  logic                 inj_arm,
    input  logic [3:0]           inj_ch,
`endif
    output logic [NCH*L1A_W-1:0] l1a_bus,
    output logic [NCH-1:0]       trig_out,
    output logic [NCH-1:0]       start_check,
    output logic                 check_in_progress,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic                 timeout_err,
    output logic [L1A_W-1:0]     evt_cnt,
    output logic [7:0]           misalign_cnt
);
    localparam int TO_W = $clog2(ACK_TO+1);
    l1a_disp_state_t state, state_n;
    logic [L1A_W-1:0] cur_tag, fifo_dout;
    logic [3:0] ch;
    logic [TO_W-1:0] to_cnt;
    logic fifo_empty, pop, last_ch, to_hit;
    assign last_ch = ch == 4'(NCH-1);
    assign to_hit = to_cnt == TO_W'(ACK_TO-1);
    l1a_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(l1a_in),
        .pop(pop),
        .din(evt_cnt + 1'b1),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !fifo_empty;
                state_n = fifo_empty ? IDLE : LOAD;
            end
            LOAD: state_n = TRIG;
            TRIG: state_n = WAIT;
            WAIT: state_n = finish_ack ? (last_ch ? DONE : TRIG) : (to_hit ? DONE : WAIT);
            default: state_n = IDLE;
        endcase
    end
    assign check_in_progress = state inside {LOAD, TRIG, WAIT};
    assign start_check = {NCH{check_in_progress}};
    assign trig_out = (state == TRIG) ? NCH'(1) << ch : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_tag <= '0;
            ch <= '0;
            to_cnt <= '0;
            evt_cnt <= '0;
            overflow <= 1'b0;
            timeout_err <= 1'b0;
            misalign_cnt <= '0;
        end else begin
            if (l1a_in) evt_cnt <= evt_cnt + 1'b1;
            if (l1a_in && fifo_full && !pop) overflow <= 1'b1;
            if (pop) cur_tag <= fifo_dout;
            if (state == LOAD) ch <= '0;
            if (state == TRIG) to_cnt <= '0;
            if (state == WAIT) begin
                to_cnt <= to_cnt + 1'b1;
                if (finish_ack && !last_ch) ch <= ch + 1'b1;
                if (finish_ack && last_ch && !align_in && misalign_cnt != 8'hff) misalign_cnt <= misalign_cnt + 1'b1;
                if (!finish_ack && to_hit) timeout_err <= 1'b1;
            end
        end
    end
`ifdef L1A_ERR_INJECT_EN
    logic armed;
    logic [3:0] inj_ch_q;
    logic [NCH-1:0] inj_mask;
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            inj_ch_q <= '0;
            inj_mask <= '0;
        end else begin
            armed <= inj_arm || (armed && !pop);
            if (inj_arm) inj_ch_q <= inj_ch;
            if (pop) inj_mask <= armed ? NCH'(1) << inj_ch_q : '0;
        end
    end
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign l1a_bus[k*L1A_W +: L1A_W] = cur_tag ^ L1A_W'(inj_mask[k]);
    end
`else
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign l1a_bus[k*L1A_W +: L1A_W] = cur_tag;
    end
`endif
endmodule

// File: tb/tb_l1a_tag_dispatcher.sv
// tb_l1a_tag_dispatcher: directed self-checking bench for l1a_tag_dispatcher
module tb_l1a_tag_dispatcher;
    import l1a_pkg::*;
    localparam int NCH = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int ACK_TO = 255;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic l1a_in = 1'b0;
    logic finish_ack = 1'b0;
    logic align_in = 1'b0;
    logic [NCH*L1A_W-1:0] l1a_bus;
    logic [NCH-1:0] trig_out, start_check;
    logic check_in_progress, fifo_full, overflow, timeout_err;
    logic [L1A_W-1:0] evt_cnt;
    logic [7:0] misalign_cnt;
`ifdef L1A_ERR_INJECT_EN
    logic inj_arm = 1'b0;
    logic [3:0] inj_ch = 4'd0;
`endif
    int checks = 0;
    int errors = 0;
    int trans_cnt = 0;
    logic [L1A_W-1:0] tags [$];
    bit resp_en = 1'b0;
    bit align_val = 1'b1;
    bit kick = 1'b0;
    int ack_dly = 1;
    always #5 clk = ~clk;
    l1a_tag_dispatcher #(.NCH(NCH), .FIFO_DEPTH(FIFO_DEPTH), .ACK_TO(ACK_TO)) dut (
        .clk(clk),
        .reset(reset),
        .l1a_in(l1a_in),
        .finish_ack(finish_ack),
        .align_in(align_in),
`ifdef L1A_ERR_INJECT_EN
        .inj_arm(inj_arm),
        .inj_ch(inj_ch),
`endif
        .l1a_bus(l1a_bus),
        .trig_out(trig_out),
        .start_check(start_check),
        .check_in_progress(check_in_progress),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .timeout_err(timeout_err),
        .evt_cnt(evt_cnt),
        .misalign_cnt(misalign_cnt)
    );
    function automatic logic [L1A_W-1:0] lane(input int k);
        return lane_tag((MAX_NCH*L1A_W)'(l1a_bus), k);
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        l1a_in = 1'b0;
        tick();
        reset = 1'b0;
        tags.delete();
        trans_cnt = 0;
    endtask
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            l1a_in = 1'b1;
            tick();
        end
        l1a_in = 1'b0;
    endtask
    task automatic wait_trans(input string tag, input int n, input int budget);
        int b = budget;
        while (trans_cnt < n && b > 0) begin
            tick();
            b--;
        end
        while (check_in_progress && b > 0) begin
            tick();
            b--;
        end
        check(tag, trans_cnt, n);
    endtask
    task automatic check_zero(input string p);
        check({p, "_bus"}, l1a_bus, 0);
        check({p, "_trig"}, trig_out, 0);
        check({p, "_start"}, start_check, 0);
        check({p, "_cip"}, check_in_progress, 0);
        check({p, "_full"}, fifo_full, 0);
        check({p, "_ovf"}, overflow, 0);
        check({p, "_to"}, timeout_err, 0);
        check({p, "_evt"}, evt_cnt, 0);
        check({p, "_mis"}, misalign_cnt, 0);
    endtask
    initial begin
        int pend = 0;
        bit last = 1'b0;
        forever begin
            @(negedge clk);
            finish_ack = 1'b0;
            align_in = 1'b0;
            if (reset) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    finish_ack = 1'b1;
                    align_in = last ? align_val : 1'b0;
                end
            end else if (kick) begin
                kick = 1'b0;
                pend = 1;
                last = 1'b0;
            end else if (resp_en && trig_out != 0) begin
                pend = ack_dly;
                last = trig_out[NCH-1];
            end
        end
    end
    initial begin
        forever begin
            @(negedge clk);
            if (trig_out != 0) begin
                check("trig_onehot", $countones(trig_out), 1);
                check("lane_eq", lane(NCH-1), lane(0));
                if (trig_out[0]) begin
                    trans_cnt++;
                    tags.push_back(lane(0));
                end
            end
        end
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int b, n, q, chg;
        logic [NCH*L1A_W-1:0] prev;
        do_reset();
        check_zero("rst");
        resp_en = 1'b1;
        ack_dly = 3;
        align_val = 1'b1;
        pulse(1);
        check("t1_evt", evt_cnt, 1);
        tick();
        check("t1_lane0", lane(0), 1);
        check("t1_lane1", lane(1), 1);
        check("t1_cip_load", check_in_progress, 1);
        check("t1_start", start_check, 2'b11);
        check("t1_trig_load", trig_out, 0);
        tick();
        check("t1_trig0", trig_out, 2'b01);
        tick(3);
        check("t1_trig_wait", trig_out, 0);
        check("t1_cip_wait", check_in_progress, 1);
        tick();
        check("t1_trig1", trig_out, 2'b10);
        tick(3);
        check("t1_cip_wait2", check_in_progress, 1);
        tick();
        check("t1_cip_done", check_in_progress, 0);
        check("t1_start_done", start_check, 0);
        check("t1_mis", misalign_cnt, 0);
        check("t1_to", timeout_err, 0);
        check("t1_trans", trans_cnt, 1);
        do_reset();
        resp_en = 1'b0;
        pulse(10);
        check("t2_full", fifo_full, 1);
        check("t2_ovf", overflow, 1);
        check("t2_evt", evt_cnt, 10);
        resp_en = 1'b1;
        ack_dly = 2;
        kick = 1'b1;
        wait_trans("t2_trans", 9, 400);
        tick(40);
        check("t2_trans_final", trans_cnt, 9);
        for (int i = 0; i < 9; i++) check("t2_tag", i < tags.size() ? 32'(tags[i]) : 32'hffffffff, i + 1);
        check("t2_full_after", fifo_full, 0);
        check("t2_to", timeout_err, 0);
        do_reset();
        resp_en = 1'b0;
        pulse(1);
        b = 0;
        while (trig_out == 0 && b < 20) begin
            tick();
            b++;
        end
        check("t4_trig_seen", trig_out, 2'b01);
        n = 0;
        while (!timeout_err && n < 400) begin
            tick();
            n++;
        end
        check("t4_to_delay", n, ACK_TO + 1);
        check("t4_cip_done", check_in_progress, 0);
        tick();
        check("t4_cip_idle", check_in_progress, 0);
        resp_en = 1'b1;
        ack_dly = 2;
        pulse(1);
        wait_trans("t4_next", 2, 100);
        check("t4_tag2", tags.size() > 1 ? 32'(tags[1]) : 32'hffffffff, 2);
        check("t4_to_sticky", timeout_err, 1);
        check("t4_mis", misalign_cnt, 0);
        do_reset();
        resp_en = 1'b1;
        ack_dly = 1;
        align_val = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            pulse(1);
            wait_trans("t5_trans", i, 50);
            if (i == 100 || i == 255 || i == 300) check("t5_mis", misalign_cnt, i > 255 ? 255 : i);
        end
        do_reset();
        resp_en = 1'b1;
        ack_dly = 1;
        align_val = 1'b1;
        pulse(16383);
        q = 0;
        b = 0;
        while (q < 20 && b < 1000) begin
            tick();
            b++;
            q = check_in_progress ? 0 : q + 1;
        end
        check("t3_drain", q, 20);
        check("t3_evt_max", evt_cnt, 16383);
        check("t3_mis", misalign_cnt, 0);
        tags.delete();
        trans_cnt = 0;
        prev = l1a_bus;
        chg = 0;
        pulse(1);
        for (int i = 0; i < 12; i++) begin
            if (l1a_bus !== prev) chg++;
            prev = l1a_bus;
            tick();
        end
        check("t3_bus_changes", chg, 1);
        check("t3_lane0", lane(0), 0);
        check("t3_lane1", lane(1), 0);
        check("t3_evt_wrap", evt_cnt, 0);
        check("t3_trans", trans_cnt, 1);
        check("t3_tag", tags.size() > 0 ? 32'(tags[0]) : 32'hffffffff, 0);
        do_reset();
        resp_en = 1'b0;
        pulse(4);
        b = 0;
        while (trig_out == 0 && b < 20) begin
            tick();
            b++;
        end
        tick(3);
        check("t6_in_wait", check_in_progress, 1);
        check("t6_evt_pre", evt_cnt, 4);
        reset = 1'b1;
        tick();
        check_zero("t6");
        reset = 1'b0;
        tags.delete();
        trans_cnt = 0;
        tick(10);
        check("t6_no_trans", trans_cnt, 0);
        check("t6_idle", check_in_progress, 0);
        resp_en = 1'b1;
        ack_dly = 2;
        align_val = 1'b1;
        pulse(1);
        wait_trans("t6_trans", 1, 50);
        check("t6_tag", tags.size() > 0 ? 32'(tags[0]) : 32'hffffffff, 1);
        check("t6_evt", evt_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
